// File: rtl/lsu_pkg.sv
// Shared types, funct3 codes and decode helpers for the load/store controller.
package lsu_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned F3_BITS = 3;

  localparam logic [F3_BITS-1:0] F3_B  = 3'b000;
  localparam logic [F3_BITS-1:0] F3_H  = 3'b001;
  localparam logic [F3_BITS-1:0] F3_W  = 3'b010;
  localparam logic [F3_BITS-1:0] F3_BU = 3'b100;
  localparam logic [F3_BITS-1:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } lsu_state_e;

  typedef struct packed {
    logic               we;
    logic [F3_BITS-1:0] funct3;
    logic [XLEN-1:0]    addr;
    logic [XLEN-1:0]    wdata;
  } lsu_req_t;

  // Access width in bytes; the low two funct3 bits carry the size for every legal code.
  function automatic logic [2:0] size_bytes(input logic [F3_BITS-1:0] funct3);
    case (funct3[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic funct3_legal(input logic we, input logic [F3_BITS-1:0] funct3);
    if (we) return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
           (funct3 == F3_BU) || (funct3 == F3_HU);
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Request, response and data-memory signals between the CPU/memory side and lsu_ctrl.
interface lsu_if;
  import lsu_pkg::*;

  logic                req_valid;
  logic                req_ready;
  logic                req_we;
  logic [F3_BITS-1:0]  req_funct3;
  logic [XLEN-1:0]     req_addr;
  logic [XLEN-1:0]     req_wdata;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [XLEN-1:0]     rsp_data;
  logic                rsp_fault;
  logic [XLEN-1:0]     mem_addr;
  logic [XLEN-1:0]     mem_write_data;
  logic                mem_read_en;
  logic                mem_write_byte_en;
  logic                mem_write_half_en;
  logic                mem_write_word_en;
  logic [XLEN-1:0]     mem_read_data;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, mem_read_data,
    output req_ready, rsp_valid, rsp_data, rsp_fault,
    output mem_addr, mem_write_data, mem_read_en,
    output mem_write_byte_en, mem_write_half_en, mem_write_word_en
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, mem_read_data,
    input  req_ready, rsp_valid, rsp_data, rsp_fault,
    input  mem_addr, mem_write_data, mem_read_en,
    input  mem_write_byte_en, mem_write_half_en, mem_write_word_en
  );

endinterface

// File: rtl/lsu_extend.sv
// Sign/zero extension of raw memory read data according to the load funct3.
module lsu_extend
  import lsu_pkg::*;
(
  input  logic [F3_BITS-1:0] funct3,
  input  logic [XLEN-1:0]    raw,
  output logic [XLEN-1:0]    ext_c
);

  always_comb begin
    ext_c = raw;
    case (funct3)
      F3_B:    ext_c = {{(XLEN-8){raw[7]}}, raw[7:0]};
      F3_H:    ext_c = {{(XLEN-16){raw[15]}}, raw[15:0]};
      F3_BU:   ext_c = {{(XLEN-8){1'b0}}, raw[7:0]};
      F3_HU:   ext_c = {{(XLEN-16){1'b0}}, raw[15:0]};
      default: ext_c = raw;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: one request at a time, fault screening, single-cycle memory
// access, and exactly one response per request.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES   = 8192,
  parameter bit          ALIGN_CHECK = 1'b1
) (
  input  logic  clk,
  input  logic  rst_n,
  lsu_if.slave  bus
);

  lsu_state_e      state_q, state_d;
  lsu_req_t        req_q, req_d;
  logic            fault_q, fault_d;
  logic [XLEN-1:0] rsp_data_q, rsp_data_d;
  logic            rsp_fault_q, rsp_fault_d;

  logic [2:0]      req_size_c;
  logic [XLEN:0]   req_last_c;
  logic            req_oob_c;
  logic            req_misalign_c;
  logic            req_fault_c;
  logic [XLEN-1:0] load_ext_c;
  logic [XLEN-1:0] store_data_c;
  logic            in_access_c;
  logic            access_ok_c;

  // Fault screening of the incoming request; last byte computed one bit wider so it cannot wrap.
  always_comb begin
    req_size_c     = size_bytes(bus.req_funct3);
    req_last_c     = {1'b0, bus.req_addr} + (XLEN+1)'(req_size_c) - (XLEN+1)'(1);
    req_oob_c      = req_last_c >= (XLEN+1)'(MEM_BYTES);
    req_misalign_c = 1'b0;
    case (req_size_c)
      3'd2:    req_misalign_c = bus.req_addr[0];
      3'd4:    req_misalign_c = |bus.req_addr[1:0];
      default: req_misalign_c = 1'b0;
    endcase
    req_fault_c = !funct3_legal(bus.req_we, bus.req_funct3) || req_oob_c ||
                  (ALIGN_CHECK && req_misalign_c);
  end

  lsu_extend u_extend (
    .funct3 (req_q.funct3),
    .raw    (bus.mem_read_data),
    .ext_c  (load_ext_c)
  );

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    fault_d     = fault_q;
    rsp_data_d  = rsp_data_q;
    rsp_fault_d = rsp_fault_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          req_d   = '{we: bus.req_we, funct3: bus.req_funct3,
                      addr: bus.req_addr, wdata: bus.req_wdata};
          fault_d = req_fault_c;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        rsp_fault_d = fault_q;
        rsp_data_d  = (!fault_q && !req_q.we) ? load_ext_c : '0;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (bus.rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      fault_q     <= 1'b0;
      rsp_data_q  <= '0;
      rsp_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      fault_q     <= fault_d;
      rsp_data_q  <= rsp_data_d;
      rsp_fault_q <= rsp_fault_d;
    end
  end

  // Memory side is decoded from registered state; enables also drop while reset is asserted.
  always_comb begin
    case (req_q.funct3[1:0])
      2'b00:   store_data_c = {{(XLEN-8){1'b0}}, req_q.wdata[7:0]};
      2'b01:   store_data_c = {{(XLEN-16){1'b0}}, req_q.wdata[15:0]};
      default: store_data_c = req_q.wdata;
    endcase
    in_access_c = state_q == ST_ACCESS;
    access_ok_c = in_access_c && !fault_q && rst_n;
  end

  assign bus.req_ready         = state_q == ST_IDLE;
  assign bus.rsp_valid         = state_q == ST_RESP;
  assign bus.rsp_data          = rsp_data_q;
  assign bus.rsp_fault         = rsp_fault_q;
  assign bus.mem_addr          = in_access_c ? req_q.addr : '0;
  assign bus.mem_write_data    = in_access_c ? store_data_c : '0;
  assign bus.mem_read_en       = access_ok_c && !req_q.we;
  assign bus.mem_write_byte_en = access_ok_c && req_q.we && (req_q.funct3 == F3_B);
  assign bus.mem_write_half_en = access_ok_c && req_q.we && (req_q.funct3 == F3_H);
  assign bus.mem_write_word_en = access_ok_c && req_q.we && (req_q.funct3 == F3_W);

endmodule
